// File: rtl/alu_pkg.sv
// Shared types and funct codes for the multi-cycle ALU unit.
package alu_pkg;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MULT,
    ALU_MULTU,
    ALU_MFHI,
    ALU_MFLO,
    ALU_ILLEGAL
  } alu_ctrl_t;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational alu_op/funct decode into an ALU control code.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_ctrl_t  ctrl
);

  always_comb begin
    ctrl = ALU_ILLEGAL;
    if (!alu_op[1]) begin
      ctrl = alu_op[0] ? ALU_SUB : ALU_ADD;
    end else begin
      case (funct)
        F_ADD:   ctrl = ALU_ADD;
        F_SUB:   ctrl = ALU_SUB;
        F_AND:   ctrl = ALU_AND;
        F_OR:    ctrl = ALU_OR;
        F_SLT:   ctrl = ALU_SLT;
        F_MULT:  ctrl = ALU_MULT;
        F_MULTU: ctrl = ALU_MULTU;
        F_MFHI:  ctrl = ALU_MFHI;
        F_MFLO:  ctrl = ALU_MFLO;
        default: ctrl = ALU_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/alu_mc_unit.sv
// Multi-cycle ALU: single-cycle ops plus iterative shift-add multiply
// with HI/LO registers, behind a start/done handshake.
module alu_mc_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  alu_ctrl_t        ctrl;
  state_t           state;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             is_mul;
  logic             is_signed;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    step;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             neg;

  alu_op_decode u_dec (
    .alu_op (alu_op),
    .funct  (funct),
    .ctrl   (ctrl)
  );

  always_comb begin
    alu_res = '0;
    case (ctrl)
      ALU_ADD:  alu_res = a + b;
      ALU_SUB:  alu_res = a - b;
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  assign is_mul    = (ctrl == ALU_MULT) || (ctrl == ALU_MULTU);
  assign is_signed = (ctrl == ALU_MULT);
  assign abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;

  // Last iteration folds in the final partial product and the sign fix
  assign step = mplier[0] ? acc + mcand : acc;
  assign prod = neg ? -step : step;
  assign busy = (state == MUL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              mcand  <= {{WIDTH{1'b0}}, abs_a};
              mplier <= abs_b;
              acc    <= '0;
              cnt    <= CW'(WIDTH);
              neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              state  <= MUL;
            end else begin
              result  <= alu_res;
              zero    <= (alu_res == '0);
              illegal <= (ctrl == ALU_ILLEGAL);
              done    <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi      <= prod[PW-1:WIDTH];
            lo      <= prod[WIDTH-1:0];
            result  <= prod[WIDTH-1:0];
            zero    <= (prod[WIDTH-1:0] == '0);
            illegal <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc_unit.sv
// Directed self-checking bench for alu_mc_unit.
module tb_alu_mc_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests;
  int n_fail;

  alu_mc_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .alu_op  (alu_op),
    .funct   (funct),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .illegal (illegal),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] va, input logic [31:0] vb);
    start  = 1'b1;
    alu_op = op;
    funct  = f;
    a      = va;
    b      = vb;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    int bcnt;
    int ndone;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    alu_op  = 2'b00;
    funct   = 6'd0;
    a       = '0;
    b       = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    issue(2'b10, 6'b100000, 32'd5, 32'd7);
    tick();
    start = 1'b0;
    chk("add_done", 64'(done), 64'd1);
    chk("add_result", 64'(result), 64'd12);
    chk("add_zero", 64'(zero), 64'd0);
    chk("add_illegal", 64'(illegal), 64'd0);
    tick();
    chk("add_done_low", 64'(done), 64'd0);

    issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h0000_0001);
    tick();
    chk("slt_done", 64'(done), 64'd1);
    chk("slt_result", 64'(result), 64'd1);
    issue(2'b10, 6'b100010, 32'd9, 32'd9);
    tick();
    chk("sub_done", 64'(done), 64'd1);
    chk("sub_result", 64'(result), 64'd0);
    chk("sub_zero", 64'(zero), 64'd1);
    issue(2'b01, 6'd0, 32'd5, 32'd7);
    tick();
    chk("op01_sub", 64'(result), 64'hFFFF_FFFE);
    issue(2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    chk("and", 64'(result), 64'h0000_F000);
    issue(2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    chk("or", 64'(result), 64'h0000_FFF0);
    issue(2'b10, 6'b101010, 32'h0000_0001, 32'hFFFF_FFFF);
    tick();
    chk("slt_false", 64'(result), 64'd0);
    start = 1'b0;
    tick();

    issue(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd4);
    tick();
    start = 1'b0;
    chk("mult_busy", 64'(busy), 64'd1);
    bcnt = 0;
    while (busy && bcnt < 100) begin
      chk("mult_nodone", 64'(done), 64'd0);
      bcnt++;
      tick();
    end
    chk("mult_busy_cycles", 64'(bcnt), 64'd32);
    chk("mult_done", 64'(done), 64'd1);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFF4);
    chk("mult_result", 64'(result), 64'hFFFF_FFF4);
    issue(2'b10, 6'b010000, 32'd0, 32'd0);
    tick();
    start = 1'b0;
    chk("mfhi_done", 64'(done), 64'd1);
    chk("mfhi_result", 64'(result), 64'hFFFF_FFFF);
    issue(2'b10, 6'b010010, 32'd0, 32'd0);
    tick();
    start = 1'b0;
    chk("mflo_result", 64'(result), 64'hFFFF_FFF4);

    issue(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) issue(2'b00, 6'd0, 32'd1, 32'd2);
      else start = 1'b0;
      tick();
      if (done) ndone++;
    end
    chk("multu_ndone", 64'(ndone), 64'd1);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);
    chk("multu_result", 64'(result), 64'h0000_0001);

    issue(2'b10, 6'b011000, 32'd7, 32'd9);
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("rstmul_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmul_busy", 64'(busy), 64'd0);
    chk("rstmul_hi", 64'(hi), 64'd0);
    chk("rstmul_lo", 64'(lo), 64'd0);
    chk("rstmul_result", 64'(result), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("rstmul_nodone", 64'(ndone), 64'd0);

    issue(2'b10, 6'b011001, 32'h0001_0000, 32'h0003_0000);
    tick();
    start = 1'b0;
    wait_done("setup_done");
    chk("setup_hi", 64'(hi), 64'd3);
    chk("setup_lo", 64'(lo), 64'd0);
    tick();
    issue(2'b10, 6'b111111, 32'd5, 32'd5);
    tick();
    start = 1'b0;
    chk("ill_done", 64'(done), 64'd1);
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("ill_result", 64'(result), 64'd0);
    chk("ill_zero", 64'(zero), 64'd1);
    chk("ill_hi", 64'(hi), 64'd3);
    chk("ill_lo", 64'(lo), 64'd0);
    tick();
    chk("ill_held", 64'(illegal), 64'd1);
    issue(2'b00, 6'd0, 32'd1, 32'd1);
    tick();
    start = 1'b0;
    chk("ill_clear", 64'(illegal), 64'd0);
    chk("ill_clear_res", 64'(result), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc_unit.md
# alu_mc_unit

Parametrised multi-cycle ALU execution unit for the MIPS datapath.
- Decodes `alu_op`/`funct` and executes the operation; registered results are returned through a start/done handshake.
- Adds what the single-cycle decode path lacks: MULT/MULTU via an iterative shift-add engine, HI/LO registers, MFHI/MFLO, and explicit flagging of unknown `funct` codes.
- Sits between the control unit and the writeback mux; the control unit stalls on `busy`.

## Interface
- WIDTH, 32, datapath width; legal values are even and ≥ 8.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while `busy`=0
- alu_op  in  2  00 = add, 01 = sub, 1x = decode `funct`
- funct  in  6  R-type function field
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt / immediate)
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse; `result`/`zero`/`illegal` valid
- result  out  WIDTH  registered result; held until the next `done`
- zero  out  1  (result == 0), registered with `result`
- illegal  out  1  unknown `funct`; valid with `done`
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- `funct` decode under `alu_op`=1x:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT
  - 011000 MULT, 011001 MULTU
  - 010000 MFHI, 010010 MFLO
  - any other code is ILLEGAL
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is a signed compare; result 1 or 0, zero-extended.
  - AND/OR are bitwise.
- ILLEGAL: `result`=0, `zero`=1, `illegal`=1, `done` pulses; HI/LO unchanged.
- MULT: multiply |a| × |b| unsigned, then two's-complement-negate the 2·WIDTH product if sign(a)≠sign(b). MULTU uses operands directly.
- Product handling: HI = upper WIDTH bits, LO = lower WIDTH bits; `result` = LO.
- MFHI/MFLO: `result` = HI/LO; single-cycle.
- FSM has two states, IDLE and MUL.
  - IDLE + start + single-cycle op: register result, pulse `done`; stay in IDLE.
  - IDLE + start + MULT/MULTU: load multiplicand, multiplier, 2·WIDTH accumulator, counter=WIDTH; go to MUL.
  - MUL: one multiplier bit per cycle (add shifted multiplicand if bit set, shift, decrement counter). When the counter reaches 0: apply sign fix, write HI/LO/`result`, pulse `done`, return to IDLE.
- `start` while `busy`=1 is ignored; it is neither queued nor flagged.
- `illegal` and `zero` update only on `done`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `zero`=1, `illegal`=0, `hi`=0, `lo`=0.
- Single-cycle ops: start sampled at edge N → `done`=1 and `result` valid in the cycle after edge N (latency 1).
- Multiply:
  - start at edge N → `busy`=1 after edge N.
  - `done`=1, `busy`=0, HI/LO updated after edge N+WIDTH.
  - `busy` is high for exactly WIDTH cycles.
- Back-to-back: `start` may be high in the same cycle as `done`; it is accepted, so single-cycle ops sustain one result per cycle.
- MFHI issued in the cycle `done` is high for a MULT returns the new HI.
- Reset mid-multiply: next cycle state is IDLE, `busy`=0, HI/LO=0, no `done` pulse.
- Reset has priority over `start` in the same cycle.

## Structure
- Package `alu_pkg`:
  - `funct` localparams
  - `alu_ctrl_t` enum, 4-bit: ADD, SUB, AND, OR, SLT, MULT, MULTU, MFHI, MFLO, ILLEGAL
  - `state_t` enum: IDLE, MUL
- Sub-module `alu_op_decode`: purely combinational `alu_op`/`funct` → `alu_ctrl_t`, with a full default assignment (no latches).
- Shift-add engine and FSM are inline in `alu_mc_unit`.

## Test plan
- ADD, `alu_op`=10, `funct`=100000, a=5, b=7, start one cycle → next cycle `done`=1, `result`=12, `zero`=0, `illegal`=0.
- SLT a=FFFFFFFF, b=00000001 → `result`=1. Next cycle SUB a=b=9 → `result`=0, `zero`=1; back-to-back starts give two consecutive `done` pulses.
- MULT a=FFFFFFFD (−3), b=4 → `busy` high 32 cycles, then `done`, `hi`=FFFFFFFF, `lo`=FFFFFFF4. Follow with MFHI → `result`=FFFFFFFF.
- MULTU a=b=FFFFFFFF, with `start`=1 (ADD) pulsed at cycle 5 of `busy` → `hi`=FFFFFFFE, `lo`=00000001; exactly one `done`, and the ADD is ignored.
- MULT started, `reset` high at cycle 10 of `busy` → next cycle `busy`=0, `hi`=`lo`=0, `result`=0, no `done` for 40 cycles.
- `funct`=111111, `alu_op`=10 → next cycle `done`=1, `illegal`=1, `result`=0, `zero`=1; `hi`/`lo` keep their prior values.
